// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - opcode/funct codes, ALU operation encodings and sequencer state type
package mips_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;

   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_XOR   = 6'h26;
   localparam logic [5:0] FN_SLT   = 6'h2A;
   localparam logic [5:0] FN_SLL   = 6'h00;
   localparam logic [5:0] FN_SRL   = 6'h02;

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;
   localparam logic [2:0] ALU_AND  = 3'b010;
   localparam logic [2:0] ALU_OR   = 3'b011;
   localparam logic [2:0] ALU_SLT  = 3'b100;
   localparam logic [2:0] ALU_SLL  = 3'b101;
   localparam logic [2:0] ALU_SRL  = 3'b110;
   localparam logic [2:0] ALU_XOR  = 3'b111;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      BRANCH = 3'd5,
      ERR    = 3'd6
   } state_e;

endpackage

// File: rtl/mips_alu_decoder.sv
// rtl/mips_alu_decoder.sv - opcode/funct to ALU select, operand signedness, shift and legality (MCCTRL_SHIFT_EN enables sll/srl)
module mips_alu_decoder
   import mips_ctrl_pkg::*;
(
   input  logic [5:0] opcode_i,
   input  logic [5:0] funct_i,
   output logic [2:0] alu_ctrl_o,
   output logic       sign_o,
   output logic       shift_o,
   output logic       legal_o
);

   // Pure table lookup; anything not listed is reported as illegal
   always_comb begin
      alu_ctrl_o = ALU_ADD;
      sign_o     = 1'b0;
      shift_o    = 1'b0;
      legal_o    = 1'b1;
      case (opcode_i)
         OP_RTYPE: begin
            case (funct_i)
               FN_ADD: begin alu_ctrl_o = ALU_ADD; sign_o = 1'b1; end
               FN_SUB: begin alu_ctrl_o = ALU_SUB; sign_o = 1'b1; end
               FN_AND: alu_ctrl_o = ALU_AND;
               FN_OR:  alu_ctrl_o = ALU_OR;
               FN_XOR: alu_ctrl_o = ALU_XOR;
               FN_SLT: begin alu_ctrl_o = ALU_SLT; sign_o = 1'b1; end
`ifdef MCCTRL_SHIFT_EN
               FN_SLL: begin alu_ctrl_o = ALU_SLL; shift_o = 1'b1; end
               FN_SRL: begin alu_ctrl_o = ALU_SRL; shift_o = 1'b1; end
`endif
               default: legal_o = 1'b0;
            endcase
         end
         OP_ADDI: begin alu_ctrl_o = ALU_ADD; sign_o = 1'b1; end
         OP_ANDI: alu_ctrl_o = ALU_AND;
         OP_ORI:  alu_ctrl_o = ALU_OR;
         OP_LW:   begin alu_ctrl_o = ALU_ADD; sign_o = 1'b1; end
         OP_SW:   begin alu_ctrl_o = ALU_ADD; sign_o = 1'b1; end
         OP_BEQ:  begin alu_ctrl_o = ALU_SUB; sign_o = 1'b1; end
         default: legal_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_control.sv
// rtl/mips_multicycle_control.sv - multi-cycle MIPS32 control sequencer (MCCTRL_SHIFT_EN enables sll/srl)
module mips_multicycle_control
   import mips_ctrl_pkg::*;
#(
   parameter int ILLEGAL_HOLD = 0
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instr,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic        zero,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [4:0]  shamt,
   output logic [15:0] immediate,
   output logic        RegDst,
   output logic        RegWrite,
   output logic        ALUsrc,
   output logic        MemWrite,
   output logic        MemRead,
   output logic        MemtoReg,
   output logic        oe,
   output logic        shift,
   output logic        sign1,
   output logic        sign2,
   output logic [2:0]  ALUcontrol,
   output logic        done,
   output logic        branch_taken,
   output logic        illegal
);

   state_e      state_q, state_d;
   logic [31:0] ir_q, ir_d;
   logic [2:0]  dec_alu;
   logic        dec_sign, dec_shift, dec_legal;
   logic        is_rtype, is_lw, is_sw, is_beq;
   logic        busy_d, err_entry_d;

   // Instruction register takes the offered word only on the accept edge
   assign ir_d = (state_q == IDLE && instr_valid) ? instr : ir_q;

   // Decode the instruction that will be held after this edge, so outputs can be registered
   mips_alu_decoder u_alu_decoder (
      .opcode_i   (ir_d[31:26]),
      .funct_i    (ir_d[5:0]),
      .alu_ctrl_o (dec_alu),
      .sign_o     (dec_sign),
      .shift_o    (dec_shift),
      .legal_o    (dec_legal)
   );

   assign is_rtype = (ir_d[31:26] == OP_RTYPE);
   assign is_lw    = (ir_d[31:26] == OP_LW);
   assign is_sw    = (ir_d[31:26] == OP_SW);
   assign is_beq   = (ir_d[31:26] == OP_BEQ);

   // Next-state selection for the instruction sequencer
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (instr_valid) state_d = DECODE;
         DECODE:  state_d = !dec_legal ? ERR : (is_beq ? BRANCH : EXEC);
         EXEC:    state_d = (is_lw || is_sw) ? MEM : WB;
         MEM:     state_d = is_lw ? WB : IDLE;
         WB:      state_d = IDLE;
         BRANCH:  state_d = IDLE;
         ERR:     state_d = (ILLEGAL_HOLD != 0) ? ERR : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath controls are live for every state of a legal instruction; ERR entry pulses once
   assign busy_d      = dec_legal && (state_d inside {DECODE, EXEC, MEM, WB, BRANCH});
   assign err_entry_d = (state_d == ERR) && (state_q != ERR);

   // State, instruction register and registered Moore outputs; reset clears strobes immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ir_q       <= '0;
         RegDst     <= 1'b0;
         RegWrite   <= 1'b0;
         ALUsrc     <= 1'b0;
         MemWrite   <= 1'b0;
         MemRead    <= 1'b0;
         MemtoReg   <= 1'b0;
         oe         <= 1'b0;
         shift      <= 1'b0;
         sign1      <= 1'b0;
         sign2      <= 1'b0;
         ALUcontrol <= ALU_ADD;
         done       <= 1'b0;
         illegal    <= 1'b0;
      end else begin
         state_q    <= state_d;
         ir_q       <= ir_d;
         RegDst     <= busy_d && is_rtype;
         ALUsrc     <= busy_d && (!is_rtype || dec_shift);
         shift      <= busy_d && dec_shift;
         sign1      <= busy_d && dec_sign;
         sign2      <= busy_d && dec_sign;
         ALUcontrol <= busy_d ? dec_alu : ALU_ADD;
         RegWrite   <= (state_d == WB);
         MemWrite   <= (state_d == MEM) && is_sw;
         MemRead    <= (state_d == MEM || state_d == WB) && is_lw;
         MemtoReg   <= (state_d == WB) && is_lw;
         oe         <= (state_d == WB);
         done       <= (state_d == WB) || (state_d == MEM && is_sw) ||
                       (state_d == BRANCH) || err_entry_d;
         illegal    <= err_entry_d;
      end
   end

   assign instr_ready  = (state_q == IDLE);
   assign branch_taken = (state_q == BRANCH) && zero;

   assign rs        = ir_q[25:21];
   assign rt        = ir_q[20:16];
   assign rd        = ir_q[15:11];
   assign shamt     = ir_q[10:6];
   assign immediate = ir_q[15:0];

endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb/tb_mips_multicycle_control.sv - randomized self-checking bench for the multi-cycle control sequencer
module tb_mips_multicycle_control;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] instr = '0;
   logic        instr_valid = 1'b0;
   logic        zero = 1'b0;
   logic        instr_ready;
   logic [4:0]  rs, rt, rd, shamt;
   logic [15:0] immediate;
   logic        RegDst, RegWrite, ALUsrc, MemWrite, MemRead, MemtoReg, oe, shift, sign1, sign2;
   logic [2:0]  ALUcontrol;
   logic        done, branch_taken, illegal;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef MCCTRL_SHIFT_EN
   localparam bit SHIFT_EN = 1'b1;
`else
   localparam bit SHIFT_EN = 1'b0;
`endif

   localparam logic [2:0] K_R = 3'd0, K_IMM = 3'd1, K_LW = 3'd2, K_SW = 3'd3, K_BEQ = 3'd4, K_ILL = 3'd5;

   typedef struct packed {
      logic [2:0] kind;
      logic [2:0] alu;
      logic       sgn;
      logic       shf;
   } info_t;

   always #5 clk = ~clk;

   mips_multicycle_control #(.ILLEGAL_HOLD(0)) dut (
      .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .zero(zero),
      .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .immediate(immediate),
      .RegDst(RegDst), .RegWrite(RegWrite), .ALUsrc(ALUsrc), .MemWrite(MemWrite),
      .MemRead(MemRead), .MemtoReg(MemtoReg), .oe(oe), .shift(shift),
      .sign1(sign1), .sign2(sign2), .ALUcontrol(ALUcontrol),
      .done(done), .branch_taken(branch_taken), .illegal(illegal)
   );

   function automatic logic [16:0] observed();
      return {RegDst, RegWrite, ALUsrc, MemWrite, MemRead, MemtoReg, oe, shift,
              sign1, sign2, ALUcontrol, done, branch_taken, illegal, instr_ready};
   endfunction

   // Instruction table: what each supported instruction means to the datapath
   function automatic info_t classify(input logic [31:0] w);
      info_t r;
      r = '{kind: K_ILL, alu: 3'd0, sgn: 1'b0, shf: 1'b0};
      case (w[31:26])
         6'h00: begin
            r.kind = K_R;
            case (w[5:0])
               6'h20: begin r.alu = 3'd0; r.sgn = 1'b1; end
               6'h22: begin r.alu = 3'd1; r.sgn = 1'b1; end
               6'h24: r.alu = 3'd2;
               6'h25: r.alu = 3'd3;
               6'h26: r.alu = 3'd7;
               6'h2A: begin r.alu = 3'd4; r.sgn = 1'b1; end
               6'h00: if (SHIFT_EN) begin r.alu = 3'd5; r.shf = 1'b1; end else r.kind = K_ILL;
               6'h02: if (SHIFT_EN) begin r.alu = 3'd6; r.shf = 1'b1; end else r.kind = K_ILL;
               default: r.kind = K_ILL;
            endcase
         end
         6'h08: r = '{kind: K_IMM, alu: 3'd0, sgn: 1'b1, shf: 1'b0};
         6'h0C: r = '{kind: K_IMM, alu: 3'd2, sgn: 1'b0, shf: 1'b0};
         6'h0D: r = '{kind: K_IMM, alu: 3'd3, sgn: 1'b0, shf: 1'b0};
         6'h23: r = '{kind: K_LW,  alu: 3'd0, sgn: 1'b1, shf: 1'b0};
         6'h2B: r = '{kind: K_SW,  alu: 3'd0, sgn: 1'b1, shf: 1'b0};
         6'h04: r = '{kind: K_BEQ, alu: 3'd1, sgn: 1'b1, shf: 1'b0};
         default: r.kind = K_ILL;
      endcase
      return r;
   endfunction

   // Cycles from the accept edge back to an accepting controller
   function automatic int latency(input info_t i);
      if (i.kind == K_LW) return 5;
      if (i.kind == K_BEQ || i.kind == K_ILL) return 3;
      return 4;
   endfunction

   // Expected output vector c cycles after the accept edge; z is zero during the final busy cycle
   function automatic logic [16:0] expect_vec(input info_t i, input int c, input logic z);
      int   L;
      logic ok, wr;
      L = latency(i);
      if (c >= L) return 17'd1;
      ok = (i.kind != K_ILL);
      wr = (i.kind == K_R || i.kind == K_IMM || i.kind == K_LW) && (c == L - 1);
      return {ok && i.kind == K_R,
              wr,
              ok && (i.kind != K_R || i.shf),
              i.kind == K_SW && c == 3,
              i.kind == K_LW && c >= 3,
              i.kind == K_LW && c == 4,
              wr,
              ok && i.shf,
              ok && i.sgn,
              ok && i.sgn,
              ok ? i.alu : 3'd0,
              c == L - 1,
              i.kind == K_BEQ && c == 2 && z,
              i.kind == K_ILL && c == 2,
              1'b0};
   endfunction

   // Offer one word at a negedge while idle; scramble instr after acceptance
   task automatic issue(input logic [31:0] w);
      instr       = w;
      instr_valid = 1'b1;
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      instr       = $urandom;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (observed() !== 17'd1) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b expected %b", observed(), 17'd1);
      end
      n_checks++;
      if ({rs, rt, rd, shamt, immediate} !== 36'd0) begin
         n_fail++;
         $display("FAIL reset_fields: got %h expected 0", {rs, rt, rd, shamt, immediate});
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (observed() !== 17'd1) begin
         n_fail++;
         $display("FAIL reset_idle: got %b expected %b", observed(), 17'd1);
      end
   endtask

   task automatic test_directed();
      logic [31:0] words [7] = '{32'h012A4020, 32'h8D280004, 32'hAD280004,
                                 32'h11090003, 32'h11090003, 32'hFC000000, 32'h012A4020};
      logic        zs    [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      for (int k = 0; k < 7; k++) begin
         info_t inf;
         inf  = classify(words[k]);
         zero = ~zs[k];
         issue(words[k]);
         for (int c = 1; c <= latency(inf); c++) begin
            @(negedge clk);
            n_checks++;
            if (observed() !== expect_vec(inf, c, zs[k])) begin
               n_fail++;
               $display("FAIL directed_%0d cycle %0d (%h): got %b expected %b",
                        k, c, words[k], observed(), expect_vec(inf, c, zs[k]));
            end
            if (c == 1) begin
               n_checks++;
               if ({rs, rt, rd, shamt, immediate} !== {words[k][25:6], words[k][15:0]}) begin
                  n_fail++;
                  $display("FAIL directed_fields_%0d: got %h expected %h",
                           k, {rs, rt, rd, shamt, immediate}, {words[k][25:6], words[k][15:0]});
               end
            end
            zero = (c == 1) ? zs[k] : ~zs[k];
         end
      end
   endtask

   task automatic test_random();
      logic [5:0] ops [8] = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h00};
      logic [5:0] fns [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h00, 6'h02};
      for (int k = 0; k < 60; k++) begin
         logic [31:0] w;
         logic        z;
         info_t       inf;
         w = $urandom;
         w[31:26] = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
         if (w[31:26] == 6'h00 && $urandom_range(0, 9) != 0) w[5:0] = fns[$urandom_range(0, 7)];
         z    = 1'($urandom);
         inf  = classify(w);
         zero = ~z;
         issue(w);
         for (int c = 1; c <= latency(inf); c++) begin
            @(negedge clk);
            n_checks++;
            if (observed() !== expect_vec(inf, c, z)) begin
               n_fail++;
               $display("FAIL random_%0d cycle %0d (%h): got %b expected %b",
                        k, c, w, observed(), expect_vec(inf, c, z));
            end
            if (c == 1) begin
               n_checks++;
               if ({rs, rt, rd, shamt, immediate} !== {w[25:6], w[15:0]}) begin
                  n_fail++;
                  $display("FAIL random_fields_%0d: got %h expected %h",
                           k, {rs, rt, rd, shamt, immediate}, {w[25:6], w[15:0]});
               end
            end
            zero = (c == 1) ? z : ~z;
         end
      end
   endtask

   task automatic test_busy_ignore();
      logic [31:0] a, b;
      info_t       inf;
      a   = 32'h012A4020;
      b   = 32'h8C6B7FF0;
      inf = classify(a);
      issue(a);
      for (int c = 1; c <= latency(inf); c++) begin
         @(negedge clk);
         n_checks++;
         if (observed() !== expect_vec(inf, c, 1'b0)) begin
            n_fail++;
            $display("FAIL busy_ignore cycle %0d: got %b expected %b",
                     c, observed(), expect_vec(inf, c, 1'b0));
         end
         instr       = b;
         instr_valid = (c < latency(inf) - 1);
      end
      @(negedge clk);
      n_checks++;
      if (instr_ready !== 1'b1 || {rs, rt, rd, shamt, immediate} !== {a[25:6], a[15:0]}) begin
         n_fail++;
         $display("FAIL busy_ignore_latch: got ready %b fields %h expected ready 1 fields %h",
                  instr_ready, {rs, rt, rd, shamt, immediate}, {a[25:6], a[15:0]});
      end
   endtask

   task automatic test_reset_mid_lw();
      issue(32'h8D280004);
      repeat (4) @(negedge clk);
      n_checks++;
      if ({RegWrite, MemRead, MemtoReg} !== 3'b111) begin
         n_fail++;
         $display("FAIL mid_reset_wb: got %b expected 111", {RegWrite, MemRead, MemtoReg});
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (observed() !== 17'd1) begin
         n_fail++;
         $display("FAIL mid_reset_async: got %b expected %b", observed(), 17'd1);
      end
      n_checks++;
      if ({rs, rt, rd, shamt, immediate} !== 36'd0) begin
         n_fail++;
         $display("FAIL mid_reset_fields: got %h expected 0", {rs, rt, rd, shamt, immediate});
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (observed() !== 17'd1) begin
         n_fail++;
         $display("FAIL mid_reset_release: got %b expected %b", observed(), 17'd1);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_busy_ignore();
      test_random();
      test_reset_mid_lw();
      test_directed();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Multi-cycle control sequencer that drives the single-cycle MIPS32 datapath's control and field inputs from a fetched instruction word.
- Accepts one instruction through a valid/ready handshake and latches it.
- Steps it through decode, execute, memory and writeback states, holding every datapath control line stable across those states.
- Uses the datapath's zero flag (`beq` output) to resolve branches and reports completion to the fetch side.
- Sits between the instruction-memory/PC logic and the datapath.

## Interface
Parameters:
- `ILLEGAL_HOLD`, default 0. When 1, an illegal opcode parks the FSM in `ERR` until reset. When 0, it returns to `IDLE` after one cycle.

Ports:
- `clk`  in  1  — rising-edge clock shared with the datapath.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `instr`  in  32  — instruction word; sampled when `instr_valid && instr_ready`.
- `instr_valid`  in  1  — fetch side offers an instruction.
- `instr_ready`  out  1  — controller can accept; high only in `IDLE`.
- `zero`  in  1  — datapath ALU zero flag (`beq`).
- `rs`, `rt`, `rd`, `shamt`  out  5 each  — fields of the latched instruction.
- `immediate`  out  16  — `instr[15:0]` of the latched instruction.
- `RegDst`, `RegWrite`, `ALUsrc`, `MemWrite`, `MemRead`, `MemtoReg`, `oe`, `shift`, `sign1`, `sign2`  out  1 each  — datapath controls.
- `ALUcontrol`  out  3  — ALU operation select.
- `done`  out  1  — one-cycle pulse on the last state of each instruction.
- `branch_taken`  out  1  — one-cycle pulse in `BRANCH` when `zero` = 1.
- `illegal`  out  1  — one-cycle pulse on an unsupported opcode or funct.

## Operation
- States: `IDLE`, `DECODE`, `EXEC`, `MEM`, `WB`, `BRANCH`, `ERR`.
- Handshake:
  - `IDLE` moves to `DECODE` on `instr_valid`; the instruction register loads on that edge.
  - `instr_valid` without `instr_ready` is ignored; no queuing.
- ALU encoding: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT, 101 SLL, 110 SRL, 111 XOR.
- Supported instructions:
  - R-type, opcode 0x00: funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x26 xor, 0x2A slt, 0x00 sll, 0x02 srl.
  - I-type: 0x08 addi, 0x0C andi, 0x0D ori, 0x23 lw, 0x2B sw, 0x04 beq.
- Transitions from `DECODE`:
  - To `BRANCH` for beq.
  - To `ERR` for an illegal opcode or funct, with `illegal` pulsing there.
  - To `EXEC` otherwise.
- Transitions from `EXEC`:
  - To `MEM` for lw/sw.
  - To `WB` for R-type and ALU-immediate instructions.
- Remaining transitions:
  - `MEM` goes to `WB` for lw and to `IDLE` for sw.
  - `WB` goes to `IDLE`.
  - `BRANCH` goes to `IDLE`.
- Control values, driven from `DECODE` until the instruction's exit from its last state:
  - `RegDst` = 1 for R-type only.
  - `ALUsrc` = 1 for I-type and for sll/srl.
  - `shift` = 1 for sll/srl only.
  - `sign1` = `sign2` = 1 for add, sub, slt, addi, lw, sw, beq; 0 otherwise.
  - `ALUcontrol`: ADD for lw/sw/addi, SUB for beq, AND for andi, OR for ori; from funct for R-type.
- Strobes, all 0 outside the listed states:
  - `RegWrite` = 1 only in `WB`.
  - `MemWrite` = 1 only in `MEM` for sw.
  - `MemRead` = 1 in `MEM` and `WB` for lw.
  - `MemtoReg` = 1 in `WB` for lw.
  - `oe` = 1 in `WB`.
- `done` pulses in `WB`, in `MEM` for sw, in `BRANCH`, and in `ERR` (first cycle).

## Timing
- Reset:
  - `rst_n` low forces `IDLE` immediately, asynchronously.
  - Instruction register goes to 0.
  - All control outputs and pulses go to 0; field outputs go to 0.
  - `instr_ready` = 1 once in `IDLE`.
- Latency, counted from the accept edge to the return to `IDLE`:
  - R-type / ALU-immediate: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq: 3 cycles.
  - Illegal: 3 cycles with `ILLEGAL_HOLD` = 0.
- Outputs are a Moore decode of state plus the latched instruction; no combinational path from `instr` to any control.
- `zero` is sampled only in `BRANCH`; it is ignored elsewhere.
- Back-to-back operation: `instr_ready` rises the cycle after `done`; a new instruction may be accepted in that cycle.
- Reset asserted mid-instruction aborts it; `RegWrite`/`MemWrite` drop in the same instant.

## Configuration
- `MCCTRL_SHIFT_EN`:
  - Defined: sll/srl are supported, using the `shift` and `shamt` path.
  - Undefined: funct 0x00/0x02 decode as illegal, and `shift` is tied to 0.

## Structure
- Package `mips_ctrl_pkg`:
  - Opcode and funct localparams.
  - 3-bit ALU operation encodings.
  - State enum.
- Sub-module `mips_alu_decoder`: combinational opcode/funct to {`ALUcontrol`, `sign1`, `sign2`, `shift`, legal}.

## Test plan
- Reset then `add` (0x012A4020) -> 4-cycle sequence; `RegDst` = 1, `ALUcontrol` = 000, `RegWrite` = 1 only in `WB`; `done` pulses on cycle 4.
- `lw` (0x8D280004) -> `ALUsrc` = 1, `ALUcontrol` = 000, `MemRead` high for 2 cycles, `MemtoReg` = 1 and `RegWrite` = 1 in `WB`; 5-cycle latency.
- `sw` (0xAD280004) -> `MemWrite` = 1 for exactly 1 cycle, `RegWrite` never asserted; `done` pulses in `MEM`.
- `beq` with `zero` = 1, then with `zero` = 0 -> `ALUcontrol` = 001; `branch_taken` pulses only in the first case; 3-cycle latency each.
- Opcode 0x3F -> `illegal` pulses one cycle; no write strobes; `instr_ready` returns; the following `add` executes normally.
- `rst_n` dropped during `WB` of `lw` -> all strobes 0 at once; `IDLE` with `instr_ready` = 1 after release.
